// File: rtl/serial_src_pkg.sv
// Shared types and counter sizing for the serial pattern source.
package serial_src_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_SHIFT,
    SRC_GAP
  } src_state_e;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned MAX_GAP   = 15;

  // Bit counter holds bits-remaining-minus-one, so WIDTH-1 must fit.
  localparam int unsigned BIT_CNT_W = $clog2(MAX_WIDTH);
  localparam int unsigned GAP_CNT_W = $clog2(MAX_GAP + 1);

endpackage

// File: rtl/ser_word_fifo.sv
// Small synchronous show-ahead FIFO buffering words ahead of the shifter.
module ser_word_fifo
  import serial_src_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr && !do_rd)      count_d = count_q + CNT_W'(1);
    else if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/serial_pattern_source.sv
// Buffers parallel words and shifts them out one bit per clock with an
// optional idle gap between words; all serial outputs are registered.
module serial_pattern_source
  import serial_src_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned GAP      = 0,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  src_state_e             state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic                   order_q, order_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   ser_bit_q, ser_bit_d;
  logic                   ser_valid_q, ser_valid_d;
  logic                   word_done_q, word_done_d;

  logic                   load;
  logic                   fifo_full, fifo_empty;
  logic [WIDTH-1:0]       fifo_data;
  logic [$clog2(DEPTH):0] fifo_count;

  ser_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != SRC_IDLE) || (fifo_count != '0);
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    order_d     = order_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_bit_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      SRC_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      SRC_SHIFT: begin
        ser_valid_d = 1'b1;
        ser_bit_d   = order_q ? shift_q[WIDTH-1] : shift_q[0];
        shift_d     = order_q ? (shift_q << 1) : (shift_q >> 1);
        bit_cnt_d   = bit_cnt_q - BIT_CNT_W'(1);
        if (bit_cnt_q == '0) begin
          word_done_d = 1'b1;
          if (GAP > 0) begin
            state_d   = SRC_GAP;
            gap_cnt_d = GAP_CNT_W'(GAP - 1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = SRC_IDLE;
          end
        end
      end
      SRC_GAP: begin
        if (gap_cnt_q == '0) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = SRC_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = SRC_IDLE;
    endcase

    // Bit order is captured with the word so later msb_first changes cannot disturb it.
    if (load) begin
      state_d   = SRC_SHIFT;
      shift_d   = fifo_data;
      order_d   = msb_first;
      bit_cnt_d = BIT_CNT_W'(WIDTH - 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SRC_IDLE;
      shift_q     <= '0;
      order_q     <= 1'b1;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_bit_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      order_q     <= order_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Scoreboard bench: two instances (GAP=0 and GAP=2) with per-instance
// expected-bit queues drained by a negedge monitor.
module tb_serial_pattern_source;

  typedef struct packed {
    logic v;
    logic b;
    logic d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1, msb0, msb1;
  logic       in_ready0, in_ready1, ser_bit0, ser_bit1;
  logic       ser_valid0, ser_valid1, word_done0, word_done1, busy0, busy1;

  ent_t        exp0[$];
  ent_t        exp1[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          run0 = 1'b0, run1 = 1'b0, mon_en0 = 1'b1;

  serial_pattern_source #(.WIDTH(8), .DEPTH(2), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(rst0_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .msb_first(msb0), .ser_bit(ser_bit0),
    .ser_valid(ser_valid0), .word_done(word_done0), .busy(busy0)
  );

  serial_pattern_source #(.WIDTH(8), .DEPTH(2), .GAP(2), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .reset(rst1_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .msb_first(msb1), .ser_bit(ser_bit1),
    .ser_valid(ser_valid1), .word_done(word_done1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic mon_step(input int unsigned which, input logic v, input logic b, input logic d);
    ent_t e;
    bit   running;
    int   qsz;
    if (which == 0 && !mon_en0) return;
    running = (which == 0) ? run0 : run1;
    qsz     = (which == 0) ? exp0.size() : exp1.size();
    if (!running && v) begin
      if (qsz == 0) begin
        chk($sformatf("dut%0d_spurious_valid", which), v, 1'b0);
        return;
      end
      running = 1'b1;
    end
    if (running) begin
      if (which == 0) e = exp0.pop_front();
      else            e = exp1.pop_front();
      chk($sformatf("dut%0d_ser_valid", which), v, e.v);
      chk($sformatf("dut%0d_ser_bit", which), b, e.b);
      chk($sformatf("dut%0d_word_done", which), d, e.d);
      qsz = (which == 0) ? exp0.size() : exp1.size();
      if (qsz == 0) running = 1'b0;
    end
    if (which == 0) run0 = running;
    else            run1 = running;
  endtask

  task automatic push(input int unsigned which, input logic [7:0] w, input logic msb,
                      output int unsigned waited);
    bit rdy;
    waited = 0;
    @(negedge clk);
    if (which == 0) begin in_data0 = w; in_valid0 = 1'b1; msb0 = msb; end
    else            begin in_data1 = w; in_valid1 = 1'b1; msb1 = msb; end
    forever begin
      rdy = (which == 0) ? in_ready0 : in_ready1;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        bound_fail("push_accept");
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      if (which == 0) exp0.push_back('{1'b1, msb ? w[7-i] : w[i], i == 7});
      else            exp1.push_back('{1'b1, msb ? w[7-i] : w[i], i == 7});
    end
    if (which == 1) begin
      exp1.push_back('{1'b0, 1'b0, 1'b0});
      exp1.push_back('{1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic go_idle(input int unsigned which);
    @(negedge clk);
    if (which == 0) in_valid0 = 1'b0;
    else            in_valid1 = 1'b0;
  endtask

  task automatic drain(input int unsigned which);
    int unsigned n = 0;
    while (n < 300 && ((which == 0) ? (exp0.size() != 0 || busy0) : (exp1.size() != 0 || busy1))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail($sformatf("dut%0d_drain", which));
  endtask

  initial begin
    int unsigned wt, wt3, wt4;
    bit          seen;

    rst0_n = 1'b0; rst1_n = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'hFF; msb0 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 8'hFF; msb1 = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon_step(0, ser_valid0, ser_bit0, word_done0);
        mon_step(1, ser_valid1, ser_bit1, word_done1);
      end
    join_none

    // Reset with in_valid held high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_bit", ser_bit0, 1'b0);
    chk("rst_ser_valid", ser_valid0, 1'b0);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_word_done", word_done0, 1'b0);
    chk("rst_in_ready1", in_ready1, 1'b1);
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy0", busy0, 1'b0);
    chk("post_rst_busy1", busy1, 1'b0);

    // Single word MSB-first, with latency and mid-word msb_first change.
    push(0, 8'hA0, 1'b1, wt);
    exp0.push_back('{1'b0, 1'b0, 1'b0});
    go_idle(0);
    @(negedge clk);
    chk("lat_after_k1_valid", ser_valid0, 1'b0);
    @(negedge clk);
    chk("lat_after_k2_valid", ser_valid0, 1'b1);
    chk("lat_after_k2_bit", ser_bit0, 1'b1);
    msb0 = 1'b0;
    drain(0);
    msb0 = 1'b1;

    // Back-to-back words, no gap.
    push(0, 8'hA5, 1'b1, wt);
    push(0, 8'h0A, 1'b1, wt);
    chk("b2b_second_wait", wt, 0);
    exp0.push_back('{1'b0, 1'b0, 1'b0});
    go_idle(0);
    drain(0);

    // Backpressure with DEPTH=2: fourth word stalls until the second is popped.
    push(0, 8'hC3, 1'b1, wt);
    push(0, 8'h5A, 1'b1, wt);
    push(0, 8'h81, 1'b1, wt3);
    push(0, 8'h3C, 1'b1, wt4);
    chk("bp_third_wait", wt3, 0);
    chk("bp_fourth_stall", wt4, 7);
    exp0.push_back('{1'b0, 1'b0, 1'b0});
    go_idle(0);
    drain(0);

    // LSB-first with GAP=2 on the second instance.
    push(1, 8'h05, 1'b0, wt);
    push(1, 8'h05, 1'b0, wt);
    exp1.push_back('{1'b0, 1'b0, 1'b0});
    go_idle(1);
    drain(1);

    // Asynchronous reset mid-word with a second word still queued.
    mon_en0 = 1'b0;
    push(0, 8'hFF, 1'b1, wt);
    push(0, 8'h0F, 1'b1, wt);
    go_idle(0);
    repeat (3) @(negedge clk);
    chk("mid_pre_valid", ser_valid0, 1'b1);
    chk("mid_pre_busy", busy0, 1'b1);
    #1 rst0_n = 1'b0;
    #1;
    chk("mid_rst_valid", ser_valid0, 1'b0);
    chk("mid_rst_bit", ser_bit0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_in_ready", in_ready0, 1'b1);
    chk("mid_rst_word_done", word_done0, 1'b0);
    exp0.delete();
    run0 = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ser_valid0;
    end
    chk("mid_no_resume", seen, 1'b0);
    chk("mid_post_busy", busy0, 1'b0);
    mon_en0 = 1'b1;

    repeat (3) @(negedge clk);
    chk("exp0_leftover", exp0.size(), 0);
    chk("exp1_leftover", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
